// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if -- operand / result bundle between the execute stage and the mdu.
//
// Signals
//   start      request to begin the operation selected by MDOp
//   MDOp[1:0]  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   num_1      multiplicand / dividend
//   num_2      multiplier / divisor
//   hi_we      mthi write enable (IDLE only)
//   lo_we      mtlo write enable (IDLE only)
//   wdata      data for mthi / mtlo
//   busy       an operation is in progress
//   done       one-cycle pulse: HI/LO were just updated by an operation
//   div_zero   the last divide had num_2 == 0
//   hi, lo     HI / LO registers
//
// Modports
//   master  the controller side (drives requests, observes results)
//   slave   the mdu itself
// ---------------------------------------------------------------------------
interface mdu_if;
    logic        start;
    logic [1:0]  MDOp;
    logic [31:0] num_1;
    logic [31:0] num_2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, MDOp, num_1, num_2, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, MDOp, num_1, num_2, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- iterative multiply / divide unit with HI/LO result registers.
//
// Ports
//   clk    system clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   md     mdu_if.slave bundle (start/MDOp/num_1/num_2/hi_we/lo_we/wdata in,
//          busy/done/div_zero/hi/lo out)
//
// Operation
//   The start edge latches the operands, then ITER (=32) edges each perform
//   one shift-add (multiply) or one restoring-divide step on a shared 64-bit
//   accumulator. HI/LO are written only on the final edge, together with a
//   one-cycle done pulse; busy covers exactly the ITER cycles in between.
//
// Configuration macro
//   MDU_SIGNED_EN  when defined, MDOp 10/11 are signed MULT/DIV: the core
//                  runs on operand magnitudes and the sign fix-up is applied
//                  combinationally at the final write. When undefined,
//                  MDOp[1] is ignored.
// ---------------------------------------------------------------------------
module mdu #(
    parameter int ITER = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  md
);
    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [63:0] acc_q,     acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [31:0] opnd_q,    opnd_d;
    // Raw dividend, returned in HI on divide by zero.
    logic [31:0] num1_q,    num1_d;
    logic        is_div_q,  is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        dz_q,      dz_d;

    // Operand preparation
    logic        signed_op;
    logic        sgn_a, sgn_b;
    logic [31:0] mag_a, mag_b;

    // One iteration of the datapath
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [63:0] step;

    // Final result with sign fix-up
    logic [63:0] prod;
    logic [31:0] quo, rem;

`ifdef MDU_SIGNED_EN
    assign signed_op = md.MDOp[1];
`else
    assign signed_op = 1'b0;
    logic unused_mdop1;
    assign unused_mdop1 = md.MDOp[1];
`endif

    always_comb begin
        sgn_a = signed_op & md.num_1[31];
        sgn_b = signed_op & md.num_2[31];
        mag_a = sgn_a ? (~md.num_1 + 32'd1) : md.num_1;
        mag_b = sgn_b ? (~md.num_2 + 32'd1) : md.num_2;
    end

    always_comb begin
        // Shift-add: conditionally add the multiplicand into the upper half,
        // then shift the 65-bit {carry, acc} right by one.
        add_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        // Restoring divide: the remainder shifted left with the next dividend
        // bit is 33 bits wide, so a 33-bit subtract decides the quotient bit.
        shifted = acc_q[63:31];
        diff    = shifted - {1'b0, opnd_q};
        if (is_div_q) begin
            if (diff[32]) begin
                step = {shifted[31:0], acc_q[30:0], 1'b0};
            end else begin
                step = {diff[31:0], acc_q[30:0], 1'b1};
            end
        end else begin
            step = {add_sum, acc_q[31:1]};
        end
    end

    always_comb begin
        prod = neg_res_q ? (~step + 64'd1) : step;
        quo  = neg_res_q ? (~step[31:0] + 32'd1) : step[31:0];
        rem  = neg_rem_q ? (~step[63:32] + 32'd1) : step[63:32];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        num1_d    = num1_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;

        case (state_q)
            S_IDLE: begin
                if (md.start) begin
                    // A start on the same edge as mthi/mtlo drops the write.
                    state_d   = S_BUSY;
                    cnt_d     = 5'd0;
                    busy_d    = 1'b1;
                    dz_d      = 1'b0;
                    is_div_d  = md.MDOp[0];
                    num1_d    = md.num_1;
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    if (md.MDOp[0]) begin
                        acc_d  = {32'd0, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {32'd0, mag_b};
                        opnd_d = mag_a;
                    end
                end else begin
                    if (md.hi_we) hi_d = md.wdata;
                    if (md.lo_we) lo_d = md.wdata;
                end
            end
            S_BUSY: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        if (opnd_q == 32'd0) begin
                            lo_d = 32'hFFFF_FFFF;
                            hi_d = num1_q;
                            dz_d = 1'b1;
                        end else begin
                            lo_d = quo;
                            hi_d = rem;
                        end
                    end else begin
                        lo_d = prod[31:0];
                        hi_d = prod[63:32];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            num1_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            num1_q    <= num1_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign md.busy     = busy_q;
    assign md.done     = done_q;
    assign md.div_zero = dz_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu. Results are predicted with plain
// SystemVerilog arithmetic (*, /, %) on 64-bit values; inputs change #1 after
// the rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mdu;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mdu_if bus ();

    mdu #(.ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} for an operation.
    function automatic logic [63:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        bit          sgn;
        longint      sa, sb, p, q, r;
        logic [63:0] res;
`ifdef MDU_SIGNED_EN
        sgn = op[1];
`else
        sgn = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (sgn) begin
                p   = sa * sb;
                res = p;
            end else begin
                res = {32'd0, a} * {32'd0, b};
            end
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (sgn) begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    // Runs one operation from a start edge to its done cycle and checks it.
    // Leaves time at the done cycle so a following call starts back-to-back.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke,
                         input string name);
        logic [63:0] exp;
        logic [31:0] hi0, lo0;
        int          cyc;
        bit          seen, held;
        exp  = ref_model(op, a, b);
        hi0  = bus.hi;
        lo0  = bus.lo;
        held = 1'b1;
        bus.MDOp  = op;
        bus.num_1 = a;
        bus.num_2 = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // Scramble the inputs: the operation must run on the latched copies.
        bus.num_1 = $urandom;
        bus.num_2 = $urandom;
        bus.MDOp  = 2'($urandom);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.div_zero !== 1'b0)
            begin
            errors++;
            $display("FAIL %s start_state: busy=%b done=%b dz=%b required 1 0 0",
                     name, bus.busy, bus.done, bus.div_zero);
        end
        cyc  = 1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (poke && i == 3) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) begin
                cyc++;
                if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
            end
        end
        checks++;
        if (!seen || cyc != 32 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s latency: done_seen=%0d busy_cycles=%0d busy=%b required 1 32 0",
                     name, seen, cyc, bus.busy);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s hold: hi/lo changed while busy, required %h/%h", name, hi0, lo0);
        end
        checks++;
        if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h",
                     name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        checks++;
        if (bus.div_zero !== (op[0] && b == 32'd0)) begin
            errors++;
            $display("FAIL %s div_zero: got %b required %b", name, bus.div_zero,
                     (op[0] && b == 32'd0));
        end
        $display("op %s MDOp=%b a=%h b=%h -> hi=%h lo=%h dz=%b", name, op, a, b,
                 bus.hi, bus.lo, bus.div_zero);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.MDOp  = 2'b00;
        bus.num_1 = '0;
        bus.num_2 = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b required all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
        end
        $display("reset: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    endtask

    task automatic test_multu();
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        checks++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max_const: hi=%h lo=%h required fffffffe 00000001",
                     bus.hi, bus.lo);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic test_divu();
        do_op(2'b01, 32'd100, 32'd7, 1'b1, "divu_100_7_poked");
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++;
            $display("FAIL divu_const: lo=%0d hi=%0d required 14 2", bus.lo, bus.hi);
        end
    endtask

    task automatic test_div_zero();
        do_op(2'b01, 32'h1234, 32'd0, 1'b0, "divu_by_zero");
        // Back-to-back start in the done cycle; div_zero clears at that start.
        do_op(2'b00, 32'd3, 32'd5, 1'b0, "multu_3_5");
        checks++;
        if (bus.lo !== 32'd15 || bus.hi !== 32'd0 || bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL multu_after_dz: lo=%0d hi=%0d dz=%b required 15 0 0",
                     bus.lo, bus.hi, bus.div_zero);
        end
        tick();
    endtask

    task automatic test_writes();
        logic [31:0] w;
        bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_5A5A;
        tick();
        bus.lo_we = 1'b0;
        checks++;
        if (bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h required a5a5a5a5 5a5a5a5a", bus.hi, bus.lo);
        end
        $display("write: hi=%h lo=%h", bus.hi, bus.lo);
        w = $urandom;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = w;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        checks++;
        if (bus.hi !== w || bus.lo !== w) begin
            errors++;
            $display("FAIL both_we: hi=%h lo=%h required %h", bus.hi, bus.lo, w);
        end
        // start and write on the same edge: the write is dropped.
        bus.MDOp = 2'b00; bus.num_1 = 32'd2; bus.num_2 = 32'd3;
        bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = ~w;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.hi !== w || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_wins: hi=%h busy=%b required %h 1", bus.hi, bus.busy, w);
        end
        // Writes during busy are ignored.
        bus.wdata = 32'hDEAD_BEEF; bus.lo_we = 1'b1;
        tick();
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        checks++;
        if (bus.hi !== w || bus.lo !== w) begin
            errors++;
            $display("FAIL busy_write: hi=%h lo=%h required %h", bus.hi, bus.lo, w);
        end
        for (int i = 0; i < 100 && bus.done !== 1'b1; i++) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd6) begin
            errors++;
            $display("FAIL busy_write_result: done=%b hi=%h lo=%h required 1 0 6",
                     bus.done, bus.hi, bus.lo);
        end
        $display("write during busy: hi=%h lo=%h", bus.hi, bus.lo);
        tick();
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        bus.hi_we = 1'b1; bus.wdata = 32'h1357_9BDF;
        tick();
        bus.hi_we = 1'b0;
        bus.MDOp = 2'b01; bus.num_1 = 32'hFFFF_FFFF; bus.num_2 = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: hi=%h lo=%h busy=%b done=%b dz=%b required all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_done: done/busy seen after reset, required none");
        end
        $display("reset mid-divide: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    endtask

    task automatic test_signed_ops();
        do_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_m3_5");
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
`ifdef MDU_SIGNED_EN
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_m7_2_const: lo=%h hi=%h required fffffffd ffffffff",
                     bus.lo, bus.hi);
        end
`else
        checks++;
        if (bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'd1) begin
            errors++;
            $display("FAIL div_m7_2_const: lo=%h hi=%h required 7ffffffc 00000001",
                     bus.lo, bus.hi);
        end
`endif
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");
        do_op(2'b11, 32'h8765_4321, 32'd0, 1'b0, "div_signed_zero");
        do_op(2'b10, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_min_min");
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
            do_op(op, a, b, n[0], "random");
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_op(2'b01, 32'd1000, 32'd33, 1'b0, "b2b_1");
        do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0, "b2b_2");
        do_op(2'b01, 32'd5, 32'd9, 1'b0, "b2b_3");
        tick();
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_div_zero();
        test_writes();
        test_reset_mid_op();
        test_signed_ops();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
